truth_table_checker: RTL and testbench

//  Response-side companion to the exhaustive stimulus sweeps used on the small combinational circuits.
//  It drives every N_IN-bit input vector into two DUT implementations (structural and dataflow).
//  For each vector it waits a settle window, then samples both outputs.
//  It compares each sample against a golden truth table and records pass/fail, error count,
//  per-vector mismatch map and the first failing vector. Synthesizable, so a sweep can run
//  on-board as well as in simulation.

---
 rtl/truth_table_checker_pkg.sv | 26 ++
 rtl/truth_table_checker_if.sv | 31 +++
 rtl/truth_table_checker_settle_timer.sv | 31 +++
 rtl/truth_table_checker.sv | 130 +++++++++++++
 tb/tb_truth_table_checker.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table response checker: FSM encoding,
// default sweep parameters and golden tables for the small-circuit exercises.
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_t;

  localparam int TT_N_IN_DEF   = 3;
  localparam int TT_SETTLE_DEF = 4;

  // Golden tables, bit v = required output for input vector v
  localparam logic [7:0] TT_EXP_MAJ3 = 8'hE8;
  localparam logic [7:0] TT_EXP_XOR3 = 8'h96;
  localparam logic [7:0] TT_EXP_AND3 = 8'h80;
  localparam logic [7:0] TT_EXP_OR3  = 8'hFE;

  // A SETTLE of 1 still needs a one-bit counter to hold the load value 0
  function automatic int tt_cnt_w(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Bundle between the checker and the circuit pair under sweep plus the
// result observer; master is the checker side.
interface truth_table_checker_if #(
  parameter int N_IN = 3
) ();

  logic                   start;
  logic                   f_struct;
  logic                   f_flow;
  logic [N_IN-1:0]        test_vec;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_count;
  logic [(2**N_IN)-1:0]   mismatch_map;
  logic                   fail_valid;
  logic [N_IN-1:0]        first_fail_vec;

  modport master (
    input  start, f_struct, f_flow,
    output test_vec, busy, done, pass, err_count, mismatch_map,
           fail_valid, first_fail_vec
  );

  modport slave (
    output start, f_struct, f_flow,
    input  test_vec, busy, done, pass, err_count, mismatch_map,
           fail_valid, first_fail_vec
  );

endinterface

// File: rtl/truth_table_checker_settle_timer.sv
// Loadable down-counter that marks the end of each per-vector settle window.
module truth_table_checker_settle_timer
  import truth_table_checker_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero
);

  localparam int CNT_W = tt_cnt_w(SETTLE);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every N_IN-bit vector into two implementations of one circuit and
// scores both sampled outputs against a golden truth table.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                   N_IN     = TT_N_IN_DEF,
  parameter int                   SETTLE   = TT_SETTLE_DEF,
  parameter logic [(2**N_IN)-1:0] EXPECTED = TT_EXP_MAJ3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_checker_if.master bus
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  tt_state_t r_state;
  tt_state_t w_next_state;

  logic                 w_start_ok;
  logic                 w_sample;
  logic                 w_tmr_en;
  logic                 w_tmr_load;
  logic                 w_tmr_zero;
  logic                 w_last;
  logic                 w_fail;

  logic [N_IN-1:0]      r_vec;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [N_IN:0]        r_err;
  logic [(2**N_IN)-1:0] r_map;
  logic                 r_fvalid;
  logic [N_IN-1:0]      r_ffirst;

  assign w_last = (r_vec == LAST_VEC);
  assign w_fail = (bus.f_struct != EXPECTED[r_vec]) || (bus.f_flow != EXPECTED[r_vec]);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (bus.start) w_next_state = ST_SETTLE;
      ST_SETTLE:        if (w_tmr_zero) w_next_state = ST_SAMPLE;
      ST_SAMPLE:        w_next_state = w_last ? ST_DONE : ST_SETTLE;
      default:          w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start_ok = 1'b0;
    w_sample   = 1'b0;
    w_tmr_en   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: w_start_ok = bus.start;
      ST_SETTLE:        w_tmr_en   = 1'b1;
      ST_SAMPLE:        w_sample   = 1'b1;
      default:          w_start_ok = 1'b0;
    endcase
    w_tmr_load = w_start_ok || (w_sample && !w_last);
  end

  truth_table_checker_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tmr_load),
    .i_en   (w_tmr_en),
    .o_zero (w_tmr_zero)
  );

  // Vector counter and result registers; a start clears the previous sweep's results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_map    <= '0;
      r_fvalid <= 1'b0;
      r_ffirst <= '0;
    end else if (w_start_ok) begin
      r_vec    <= '0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_map    <= '0;
      r_fvalid <= 1'b0;
      r_ffirst <= '0;
    end else if (w_sample) begin
      if (w_fail) begin
        r_map[r_vec] <= 1'b1;
        r_err        <= r_err + (N_IN+1)'(1);
        if (!r_fvalid) begin
          r_fvalid <= 1'b1;
          r_ffirst <= r_vec;
        end
      end
      if (w_last) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= (r_err == '0) && !w_fail;
      end else begin
        r_vec <= r_vec + N_IN'(1);
      end
    end
  end

  assign bus.test_vec       = r_vec;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.err_count      = r_err;
  assign bus.mismatch_map   = r_map;
  assign bus.fail_valid     = r_fvalid;
  assign bus.first_fail_vec = r_ffirst;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: sweeps with good and faulty
// circuit models, mid-sweep start/reset, and settle-window hold.
module tb_truth_table_checker;

  localparam int N_IN   = 3;
  localparam int SETTLE = 4;
  localparam int NVEC   = 1 << N_IN;
  localparam int LAT    = NVEC * (SETTLE + 1);

  typedef struct {
    logic [N_IN:0]     err;
    logic [NVEC-1:0]   map;
    logic [N_IN-1:0]   first;
    logic              fv;
    logic              pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  truth_table_checker_if #(.N_IN(N_IN)) bus ();

  truth_table_checker #(
    .N_IN     (N_IN),
    .SETTLE   (SETTLE),
    .EXPECTED (8'hE8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // mode 0 good, 1 flow stuck 0, 2 struct inverted on vector 5, 3 flow inverted everywhere
  function automatic logic drv_struct(input int m, input logic [2:0] v);
    return maj(v) ^ ((m == 2) && (v == 3'd5));
  endfunction

  function automatic logic drv_flow(input int m, input logic [2:0] v);
    if (m == 1) return 1'b0;
    if (m == 3) return ~maj(v);
    return maj(v);
  endfunction

  always_comb begin
    bus.f_struct = drv_struct(mode, bus.test_vec);
    bus.f_flow   = drv_flow(mode, bus.test_vec);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input int m);
    exp_t e;
    e.err = '0; e.map = '0; e.first = '0; e.fv = 1'b0;
    for (int v = 0; v < NVEC; v++) begin
      if ((drv_struct(m, 3'(v)) != maj(3'(v))) || (drv_flow(m, 3'(v)) != maj(3'(v)))) begin
        e.err++;
        e.map[v] = 1'b1;
        if (!e.fv) begin
          e.fv    = 1'b1;
          e.first = N_IN'(v);
        end
      end
    end
    e.pass = (e.err == 0);
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_vec"},   32'(bus.test_vec), 0);
    check_val({tag, "_busy"},  32'(bus.busy), 0);
    check_val({tag, "_done"},  32'(bus.done), 0);
    check_val({tag, "_pass"},  32'(bus.pass), 0);
    check_val({tag, "_err"},   32'(bus.err_count), 0);
    check_val({tag, "_map"},   32'(bus.mismatch_map), 0);
    check_val({tag, "_fv"},    32'(bus.fail_valid), 0);
    check_val({tag, "_first"}, 32'(bus.first_fail_vec), 0);
  endtask

  task automatic start_sweep(input string tag, input int m);
    mode = m;
    push_expect(m);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val({tag, "_start_busy"}, 32'(bus.busy), 1);
    check_val({tag, "_start_done"}, 32'(bus.done), 0);
    check_val({tag, "_start_err"},  32'(bus.err_count), 0);
    check_val({tag, "_start_map"},  32'(bus.mismatch_map), 0);
    check_val({tag, "_start_fv"},   32'(bus.fail_valid), 0);
  endtask

  // poke > 0 drives start for one cycle at that cycle count, while busy
  task automatic finish_sweep(input string tag, input int poke);
    int   cnt;
    exp_t e;
    cnt = 0;
    while (!bus.done && cnt < LAT + 20) begin
      bus.start = (cnt == poke);
      tick();
      cnt++;
    end
    bus.start = 1'b0;
    check_val({tag, "_latency"}, 32'(cnt), 32'(LAT));
    check_val({tag, "_done"}, 32'(bus.done), 1);
    check_val({tag, "_busy"}, 32'(bus.busy), 0);
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check_val({tag, "_err"},   32'(bus.err_count), 32'(e.err));
      check_val({tag, "_map"},   32'(bus.mismatch_map), 32'(e.map));
      check_val({tag, "_first"}, 32'(bus.first_fail_vec), 32'(e.first));
      check_val({tag, "_fv"},    32'(bus.fail_valid), 32'(e.fv));
      check_val({tag, "_pass"},  32'(bus.pass), 32'(e.pass));
    end
    tick();
    check_val({tag, "_hold_done"}, 32'(bus.done), 1);
    check_val({tag, "_hold_err"},  32'(bus.err_count), 32'(e.err));
  endtask

  // Settle-window monitor: each vector must stay put for SETTLE+1 cycles and step by one
  logic [N_IN-1:0] mon_prev_vec;
  logic            mon_prev_busy = 1'b0;
  int              mon_run = 0;

  always @(negedge clk) begin
    if (bus.busy && !mon_prev_busy) begin
      mon_run = 1;
    end else if (bus.busy) begin
      if (bus.test_vec != mon_prev_vec) begin
        check_val("settle_hold", 32'(mon_run), 32'(SETTLE + 1));
        check_val("vec_step", 32'(bus.test_vec), 32'(mon_prev_vec + 1'b1));
        mon_run = 1;
      end else begin
        mon_run++;
      end
    end
    mon_prev_vec  = bus.test_vec;
    mon_prev_busy = bus.busy;
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b1;
    mode      = 0;
    tick();
    tick();
    check_zero("reset_with_start");
    bus.start = 1'b0;
    rst_n     = 1'b1;
    tick();
    check_zero("idle");

    start_sweep("good", 0);
    finish_sweep("good", -1);

    start_sweep("flow_stuck0", 1);
    finish_sweep("flow_stuck0", -1);

    start_sweep("struct_v5", 2);
    finish_sweep("struct_v5", -1);

    start_sweep("busy_start", 2);
    finish_sweep("busy_start", 10);

    start_sweep("all_fail", 3);
    finish_sweep("all_fail", -1);

    start_sweep("mid_reset", 1);
    repeat (17) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_zero("mid_reset");
    void'(sb.pop_front());
    tick();
    check_zero("mid_reset_idle");

    start_sweep("after_reset", 0);
    finish_sweep("after_reset", -1);

    start_sweep("fail_then", 1);
    finish_sweep("fail_then", -1);
    start_sweep("restart_good", 0);
    finish_sweep("restart_good", -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
